wb_stage_mi: RTL and testbench
==============================

Name: wb_stage_mi

Overview:
- Parametrised multi-lane writeback stage for the dual-issue pipeline; accepts one bundle of up to LANES instructions per cycle from MEM.
- Drives per-lane register-file write and forwarding information to ID.
- Serialises retiring register writes into a single-port debug trace through an internal retire FIFO.
- Back-pressures MEM when the FIFO lacks room for a bundle.

Parameters:
LANES, 2, instruction lanes per bundle (1..4)
DW, 32, register data width
AW, 5, register address width
PCW, 32, PC width
TRACE_DEPTH, 4, retire FIFO entries; must be >= LANES

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
wb_allowin  out  1  WB can accept a bundle this cycle
mem_to_wb_valid  in  1  MEM presents a bundle
mem_to_wb_lane_valid  in  LANES  per-lane valid within bundle
mem_to_wb_bus  in  LANES*(1+AW+DW+PCW)  lane i at [i*LW +: LW], LW=1+AW+DW+PCW; fields MSB->LSB {regW, waddr, wdata, pc}
wb_to_id_bus  out  LANES*(2+AW+DW)  lane i {fwd, we, waddr, wdata}, MSB->LSB
wb_empty  out  1  no bundle held and FIFO empty
debug_wb_pc  out  PCW  trace PC
debug_wb_rf_wen  out  4  trace write enable
debug_wb_rf_wnum  out  AW  trace register number
debug_wb_rf_wdata  out  DW  trace write data

Behaviour:
- Reset: one clock, synchronous active-high; reset as stated under Already decided.
  - In the cycle after reset is sampled high: wb_valid=0, FIFO count and pointers=0, all debug outputs 0, wb_to_id_bus fwd/we=0, wb_empty=1, wb_allowin=1.
  - Reset mid-operation discards the held bundle and all FIFO contents. No partial trace is emitted.
- Bundle register:
  - wb_allowin = ~wb_valid | wb_ready_go.
  - On wb_allowin: wb_valid <= mem_to_wb_valid.
  - On wb_allowin & mem_to_wb_valid: bus and lane mask are captured.
  - Data regs are not reset.
- Commit count:
  - n = popcount(lane_valid & regW) of the held bundle.
  - free = TRACE_DEPTH - count + (count != 0), i.e. the pop in the same cycle is credited.
  - wb_ready_go = (n <= free).
  - A bundle with n=0 always leaves in one cycle.
- Commit fires when wb_valid & wb_ready_go; a bundle commits exactly once.
- ID bus, lane i (combinational):
  - fwd = wb_valid & lane_valid[i] & regW[i]; asserted throughout any stall, for bypass.
  - we = fwd & wb_ready_go; this is the regfile write, single-cycle per bundle.
  - waddr and wdata are taken directly from the held data.
  - Two lanes writing the same waddr: both we asserted; ID resolves in favour of the higher lane index (program order). WB does not arbitrate.
- Retire FIFO:
  - On commit, push writing lanes in ascending lane index into consecutive slots from wptr (mod TRACE_DEPTH); count += n.
  - Pop one entry per cycle whenever count != 0. Push and pop in the same cycle are legal: count_next = count + n - pop.
  - Pointers wrap modulo TRACE_DEPTH; non-power-of-2 depth is supported via explicit wrap compare.
  - Overflow is impossible by construction. The bench asserts count <= TRACE_DEPTH every cycle.
- Debug outputs are registered from the FIFO head with 1-cycle latency after push.
  - Entry present: wen=4'hf, pc, wnum and wdata from the entry.
  - FIFO empty: all debug outputs 0.
  - Instructions with regW=0 produce no trace entry.
- wb_empty = ~wb_valid & (count == 0) & no trace entry currently being displayed; this is used for pipeline drain and ertn/idle handling.
- Latency: a bundle captured at edge k commits in cycle k (if it fits); lane j's trace appears at edge k+1+(position in FIFO).

Test Plan:
- Single lane: lane0 only, regW=1, waddr=5, wdata=0x1234, pc=0x1c000000 -> one cycle later debug shows pc=0x1c000000, wen=f, wnum=5, wdata=0x1234; we pulses once; wb_empty returns 1.
- Dual write: lanes {0,1} with waddr 3/4, pcs 0x1c000010/0x1c000014 -> trace emits lane0 then lane1 in consecutive cycles; both we in the same cycle.
- Back-pressure: DEPTH=4, dual-write bundles every cycle -> wb_allowin drops once the FIFO is full. Throughput settles to one trace per cycle; no entry is lost or duplicated, checked by a PC sequence scoreboard; fwd stays high during the stall while we stays low.
- Non-writing bundle: both lanes regW=0 while FIFO full -> bundle leaves in 1 cycle with no trace and we=0.
- Wrap/depth: TRACE_DEPTH=3, LANES=2, 20 random bundles -> trace order equals program order across pointer wrap.
- Reset: assert reset while 3 entries are queued and a bundle is stalled -> next cycle all debug outputs 0, wb_allowin=1, wb_empty=1; no stale entry appears after reset is released.

Source files
------------

// File: rtl/wb_stage_mi.sv
// Multi-lane writeback stage: regfile write/forwarding per lane to ID plus an in-order retire trace FIFO.
// A bundle commits only when all its writing lanes fit in the FIFO; otherwise it is held and MEM stalls.
module wb_stage_mi #(
  parameter int LANES       = 2,
  parameter int DW          = 32,
  parameter int AW          = 5,
  parameter int PCW         = 32,
  parameter int TRACE_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  output logic                             wb_allowin,
  input  logic                             mem_to_wb_valid,
  input  logic [LANES-1:0]                 mem_to_wb_lane_valid,
  input  logic [LANES*(1+AW+DW+PCW)-1:0]   mem_to_wb_bus,
  output logic [LANES*(2+AW+DW)-1:0]       wb_to_id_bus,
  output logic                             wb_empty,
  output logic [PCW-1:0]                   debug_wb_pc,
  output logic [3:0]                       debug_wb_rf_wen,
  output logic [AW-1:0]                    debug_wb_rf_wnum,
  output logic [DW-1:0]                    debug_wb_rf_wdata
);

  localparam int LW = 1 + AW + DW + PCW;
  localparam int EW = LW - 1;
  localparam int IW = 2 + AW + DW;
  localparam int PW = (TRACE_DEPTH > 1) ? $clog2(TRACE_DEPTH) : 1;
  localparam int CW = $clog2(TRACE_DEPTH + 1);

  logic                wb_valid_q;
  logic [LANES-1:0]    lane_q;
  logic [LANES*LW-1:0] bus_q;
  logic [EW-1:0]       fifo_q [TRACE_DEPTH];
  logic [PW-1:0]       rptr_q, rptr_d, wptr_q, wptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic                dbg_vld_q, dbg_vld_d;
  logic [EW-1:0]       dbg_q, dbg_d;

  logic [LANES-1:0]    wr;
  logic [CW-1:0]       rank [LANES];
  logic [CW-1:0]       n, n_commit;
  logic [CW:0]         free, cnt_sum;
  logic                count_nz, ready_go, commit, bypass, pop;
  logic [EW-1:0]       first_ent;
  logic [LANES-1:0]    store_en;
  logic [PW-1:0]       slot [LANES];

  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input logic [PW:0] off);
    logic [PW+1:0] s;
    s = {2'b00, base} + {1'b0, off};
    if (s >= (PW+2)'(TRACE_DEPTH)) s = s - (PW+2)'(TRACE_DEPTH);
    return s[PW-1:0];
  endfunction

  always_comb begin : lane_scan
    n         = '0;
    wr        = '0;
    first_ent = '0;
    for (int i = 0; i < LANES; i++) begin
      wr[i]   = lane_q[i] & bus_q[i*LW + LW-1];
      rank[i] = n;
      n       = n + CW'(wr[i]);
    end
    for (int i = LANES-1; i >= 0; i--) begin
      if (wr[i]) first_ent = bus_q[i*LW +: EW];
    end
  end

  // When the FIFO is empty the first writing lane goes straight to the debug register,
  // so lane 0 of a bundle is visible the edge after its commit cycle.
  always_comb begin : commit_ctl
    count_nz  = (count_q != '0);
    free      = (CW+1)'(TRACE_DEPTH) - {1'b0, count_q} + {{CW{1'b0}}, count_nz};
    ready_go  = ({1'b0, n} <= free);
    commit    = wb_valid_q & ready_go;
    n_commit  = commit ? n : '0;
    bypass    = ~count_nz & (n_commit != '0);
    pop       = count_nz | bypass;
    cnt_sum   = {1'b0, count_q} + {1'b0, n_commit} - {{CW{1'b0}}, pop};
    count_d   = cnt_sum[CW-1:0];
    wptr_d    = wrap_add(wptr_q, (PW+1)'(n_commit) - (PW+1)'(bypass));
    rptr_d    = count_nz ? wrap_add(rptr_q, (PW+1)'(1)) : rptr_q;
    store_en  = '0;
    for (int i = 0; i < LANES; i++) begin
      store_en[i] = commit & wr[i] & ~(bypass & (rank[i] == '0));
      slot[i]     = wrap_add(wptr_q, (PW+1)'(rank[i]) - (PW+1)'(bypass));
    end
    dbg_vld_d = pop;
    dbg_d     = '0;
    if (count_nz)    dbg_d = fifo_q[rptr_q];
    else if (bypass) dbg_d = first_ent;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_valid_q <= 1'b0;
      count_q    <= '0;
      rptr_q     <= '0;
      wptr_q     <= '0;
      dbg_vld_q  <= 1'b0;
      dbg_q      <= '0;
    end else begin
      if (wb_allowin) wb_valid_q <= mem_to_wb_valid;
      count_q   <= count_d;
      rptr_q    <= rptr_d;
      wptr_q    <= wptr_d;
      dbg_vld_q <= dbg_vld_d;
      dbg_q     <= dbg_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wb_allowin && mem_to_wb_valid) begin
      lane_q <= mem_to_wb_lane_valid;
      bus_q  <= mem_to_wb_bus;
    end
    for (int i = 0; i < LANES; i++) begin
      if (store_en[i]) fifo_q[slot[i]] <= bus_q[i*LW +: EW];
    end
  end

  assign wb_allowin = ~wb_valid_q | ready_go;
  assign wb_empty   = ~wb_valid_q & ~count_nz & ~dbg_vld_q;

  always_comb begin : id_bus
    wb_to_id_bus = '0;
    for (int i = 0; i < LANES; i++) begin
      wb_to_id_bus[i*IW +: IW] = {wb_valid_q & wr[i], wb_valid_q & wr[i] & ready_go,
                                  bus_q[i*LW+DW+PCW +: AW], bus_q[i*LW+PCW +: DW]};
    end
  end

  assign debug_wb_rf_wen   = {4{dbg_vld_q}};
  assign debug_wb_pc       = dbg_q[PCW-1:0];
  assign debug_wb_rf_wdata = dbg_q[PCW +: DW];
  assign debug_wb_rf_wnum  = dbg_q[PCW+DW +: AW];

endmodule

// File: tb/tb_wb_stage_mi.sv
// Directed bench for wb_stage_mi: a depth-4 and a depth-3 instance share stimulus, selected by sel.
module tb_wb_stage_mi;
  localparam int LW = 70;
  localparam int IW = 39;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          v = 1'b0;
  logic          sel = 1'b0;
  logic [1:0]    lane_valid = 2'b00;
  logic [2*LW-1:0] bus = '0;

  logic          allow4, allow3, empty4, empty3;
  logic [2*IW-1:0] id4, id3;
  logic [31:0]   pc4, pc3, wd4, wd3;
  logic [3:0]    wen4, wen3;
  logic [4:0]    wn4, wn3;

  logic          allow, empty;
  logic [2*IW-1:0] id;
  logic [31:0]   pc, wdata;
  logic [3:0]    wen;
  logic [4:0]    wnum;

  assign allow = sel ? allow3 : allow4;
  assign empty = sel ? empty3 : empty4;
  assign id    = sel ? id3 : id4;
  assign pc    = sel ? pc3 : pc4;
  assign wdata = sel ? wd3 : wd4;
  assign wen   = sel ? wen3 : wen4;
  assign wnum  = sel ? wn3 : wn4;

  always #5 clk = ~clk;

  wb_stage_mi #(.LANES(2), .DW(32), .AW(5), .PCW(32), .TRACE_DEPTH(4)) u4 (
    .clk(clk), .reset(reset), .wb_allowin(allow4),
    .mem_to_wb_valid(v & ~sel), .mem_to_wb_lane_valid(lane_valid), .mem_to_wb_bus(bus),
    .wb_to_id_bus(id4), .wb_empty(empty4), .debug_wb_pc(pc4), .debug_wb_rf_wen(wen4),
    .debug_wb_rf_wnum(wn4), .debug_wb_rf_wdata(wd4));

  wb_stage_mi #(.LANES(2), .DW(32), .AW(5), .PCW(32), .TRACE_DEPTH(3)) u3 (
    .clk(clk), .reset(reset), .wb_allowin(allow3),
    .mem_to_wb_valid(v & sel), .mem_to_wb_lane_valid(lane_valid), .mem_to_wb_bus(bus),
    .wb_to_id_bus(id3), .wb_empty(empty3), .debug_wb_pc(pc3), .debug_wb_rf_wen(wen3),
    .debug_wb_rf_wnum(wn3), .debug_wb_rf_wdata(wd3));

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int tr_cnt = 0;
  int first_tr = -1;
  int last_tr = 0;
  bit mon_en = 1'b0;
  logic [68:0] expq [$];

  always @(posedge clk) cyc++;

  // Trace scoreboard: every displayed entry must be the oldest outstanding writer, {pc, wnum, wdata}.
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (u4.count_q > 4 || u3.count_q > 3) begin
        failures++;
        $display("FAIL fifo_count_bound: count4=%0d count3=%0d, limits 4/3", u4.count_q, u3.count_q);
      end
      if (wen !== 4'h0) begin
        checks++;
        tr_cnt++;
        if (first_tr < 0) first_tr = cyc;
        last_tr = cyc;
        if (expq.size() == 0) begin
          failures++;
          $display("FAIL trace_extra: got pc=%h wnum=%0d with nothing outstanding", pc, wnum);
        end else begin
          if ({wen, pc, wnum, wdata} !== {4'hf, expq[0]}) begin
            failures++;
            $display("FAIL trace_order: got wen=%h pc=%h wnum=%0d wdata=%h, required wen=f pc=%h wnum=%0d wdata=%h",
                     wen, pc, wnum, wdata, expq[0][68:37], expq[0][36:32], expq[0][31:0]);
          end
          void'(expq.pop_front());
        end
      end
    end
  end

  function automatic logic [LW-1:0] mk(input logic rw, input logic [4:0] a, input logic [31:0] d,
                                       input logic [31:0] p);
    return {rw, a, d, p};
  endfunction

  function automatic logic [68:0] ent(input logic [LW-1:0] l);
    return {l[31:0], l[68:64], l[63:32]};
  endfunction

  // Presents a bundle, waits (bounded) for acceptance, records writers; returns one negedge after capture.
  task automatic send(input logic [1:0] lv, input logic [LW-1:0] l0, input logic [LW-1:0] l1);
    int w = 0;
    v = 1'b1;
    lane_valid = lv;
    bus = {l1, l0};
    while (allow !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (allow !== 1'b1) begin
      failures++;
      $display("FAIL accept_timeout: allowin=%b after %0d cycles, required 1", allow, w);
    end
    if (lv[0] && l0[LW-1]) expq.push_back(ent(l0));
    if (lv[1] && l1[LW-1]) expq.push_back(ent(l1));
    @(negedge clk);
    v = 1'b0;
  endtask

  task automatic drain(input string name, input int base, input int n_tr);
    int w = 0;
    while (empty !== 1'b1 && w < 200) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (empty !== 1'b1 || expq.size() != 0 || tr_cnt - base != n_tr) begin
      failures++;
      $display("FAIL %s_drain: empty=%b pending=%0d traces=%0d, required empty=1 pending=0 traces=%0d",
               name, empty, expq.size(), tr_cnt - base, n_tr);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    v = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (allow !== 1'b1 || empty !== 1'b1) begin
      failures++;
      $display("FAIL reset_handshake: allowin=%b empty=%b, required 1 1", allow, empty);
    end
    checks++;
    if ({wen, pc, wnum, wdata} !== '0) begin
      failures++;
      $display("FAIL reset_debug: wen=%h pc=%h wnum=%0d wdata=%h, required all 0", wen, pc, wnum, wdata);
    end
    checks++;
    if ({id[77], id[76], id[38], id[37]} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_fwd_we: %b, required 0000", {id[77], id[76], id[38], id[37]});
    end
    reset = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic test_single;
    send(2'b01, mk(1'b1, 5'd5, 32'h1234, 32'h1c000000), mk(1'b0, 5'd0, 32'h0, 32'h0));
    checks++;
    if (id[IW-1:0] !== {1'b1, 1'b1, 5'd5, 32'h1234} || id[77:76] !== 2'b00 || empty !== 1'b0) begin
      failures++;
      $display("FAIL single_commit: lane0=%h lane1 fwd/we=%b empty=%b, required lane0=%h lane1 00 empty 0",
               id[IW-1:0], id[77:76], empty, {1'b1, 1'b1, 5'd5, 32'h1234});
    end
    @(negedge clk);
    checks++;
    if ({wen, pc, wnum, wdata} !== {4'hf, 32'h1c000000, 5'd5, 32'h1234} || id[38:37] !== 2'b00) begin
      failures++;
      $display("FAIL single_trace: wen=%h pc=%h wnum=%0d wdata=%h we/fwd=%b, required f 1c000000 5 00001234 00",
               wen, pc, wnum, wdata, id[38:37]);
    end
    @(negedge clk);
    checks++;
    if (wen !== 4'h0 || empty !== 1'b1) begin
      failures++;
      $display("FAIL single_empty: wen=%h empty=%b, required 0 1", wen, empty);
    end
  endtask

  task automatic test_dual;
    send(2'b11, mk(1'b1, 5'd3, 32'haaaa0003, 32'h1c000010), mk(1'b1, 5'd4, 32'hbbbb0004, 32'h1c000014));
    checks++;
    if ({id[77], id[76], id[38], id[37]} !== 4'b1111) begin
      failures++;
      $display("FAIL dual_we: fwd1 we1 fwd0 we0=%b, required 1111", {id[77], id[76], id[38], id[37]});
    end
    @(negedge clk);
    checks++;
    if (pc !== 32'h1c000010 || wnum !== 5'd3) begin
      failures++;
      $display("FAIL dual_first: pc=%h wnum=%0d, required 1c000010 3", pc, wnum);
    end
    @(negedge clk);
    checks++;
    if (pc !== 32'h1c000014 || wnum !== 5'd4 || wen !== 4'hf) begin
      failures++;
      $display("FAIL dual_second: pc=%h wnum=%0d wen=%h, required 1c000014 4 f", pc, wnum, wen);
    end
    @(negedge clk);
    checks++;
    if (wen !== 4'h0) begin
      failures++;
      $display("FAIL dual_done: wen=%h, required 0", wen);
    end
  endtask

  task automatic test_backpressure;
    int stalls = 0;
    int w;
    int base = tr_cnt;
    logic [31:0] p;
    logic [LW-1:0] l0, l1;
    sel = 1'b0;
    first_tr = -1;
    for (int b = 0; b < 8; b++) begin
      p = 32'h1c001000 + 32'(b * 8);
      l0 = mk(1'b1, 5'(2 * b + 1), 32'h5000 + 32'(b), p);
      l1 = mk(1'b1, 5'(2 * b + 2), 32'h6000 + 32'(b), p + 32'd4);
      v = 1'b1;
      lane_valid = 2'b11;
      bus = {l1, l0};
      w = 0;
      while (allow !== 1'b1 && w < 20) begin
        stalls++;
        checks++;
        if ({id[77], id[76], id[38], id[37]} !== 4'b1010) begin
          failures++;
          $display("FAIL stall_fwd_we: fwd1 we1 fwd0 we0=%b, required 1010", {id[77], id[76], id[38], id[37]});
        end
        @(negedge clk);
        w++;
      end
      checks++;
      if (allow !== 1'b1) begin
        failures++;
        $display("FAIL bp_accept_timeout: allowin=%b, required 1", allow);
      end
      expq.push_back(ent(l0));
      expq.push_back(ent(l1));
      @(negedge clk);
    end
    v = 1'b0;
    drain("backpressure", base, 16);
    checks++;
    if (stalls == 0) begin
      failures++;
      $display("FAIL allowin_drop: stall cycles=%0d, required >0", stalls);
    end
    checks++;
    if (last_tr - first_tr != 15) begin
      failures++;
      $display("FAIL bp_throughput: 16 traces spanned %0d cycles, required 16", last_tr - first_tr + 1);
    end
  endtask

  task automatic test_nonwrite;
    int w = 0;
    int base = tr_cnt;
    for (int b = 0; b < 4; b++) begin
      send(2'b11, mk(1'b1, 5'(10 + b), 32'h7000 + 32'(b), 32'h1c002000 + 32'(b * 8)),
           mk(1'b1, 5'(20 + b), 32'h8000 + 32'(b), 32'h1c002004 + 32'(b * 8)));
    end
    v = 1'b1;
    lane_valid = 2'b11;
    bus = {mk(1'b0, 5'd9, 32'hdead, 32'h1c002100), mk(1'b0, 5'd8, 32'hbeef, 32'h1c0020fc)};
    while (allow !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    @(negedge clk);
    v = 1'b0;
    checks++;
    if (u4.count_q !== 3'd4) begin
      failures++;
      $display("FAIL nonwrite_fifo_full: count=%0d, required 4", u4.count_q);
    end
    checks++;
    if (allow !== 1'b1 || {id[77], id[76], id[38], id[37]} !== 4'b0000) begin
      failures++;
      $display("FAIL nonwrite_leave: allowin=%b fwd/we=%b, required 1 0000", allow, {id[77], id[76], id[38], id[37]});
    end
    drain("nonwrite", base, 8);
  endtask

  task automatic test_wrap;
    int base = tr_cnt;
    int nexp = 0;
    logic [1:0] lv;
    logic r0, r1;
    sel = 1'b1;
    for (int b = 0; b < 20; b++) begin
      lv = 2'($urandom_range(1, 3));
      r0 = ($urandom_range(0, 3) != 0);
      r1 = ($urandom_range(0, 3) != 0);
      if (lv[0] && r0) nexp++;
      if (lv[1] && r1) nexp++;
      send(lv, mk(r0, 5'($urandom_range(0, 31)), $urandom, 32'h1c003000 + 32'(b * 8)),
           mk(r1, 5'($urandom_range(0, 31)), $urandom, 32'h1c003004 + 32'(b * 8)));
    end
    drain("wrap", base, nexp);
    sel = 1'b0;
  endtask

  task automatic test_reset_mid;
    int w = 0;
    int b = 0;
    logic [LW-1:0] l0, l1;
    sel = 1'b0;
    while (w < 30) begin
      l0 = mk(1'b1, 5'd1, 32'(b), 32'h1c004000 + 32'(b * 8));
      l1 = mk(1'b1, 5'd2, 32'(b), 32'h1c004004 + 32'(b * 8));
      v = 1'b1;
      lane_valid = 2'b11;
      bus = {l1, l0};
      if (allow !== 1'b1) break;
      expq.push_back(ent(l0));
      expq.push_back(ent(l1));
      @(negedge clk);
      b++;
      w++;
    end
    checks++;
    if (allow !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_stall: allowin=%b, required 0 before reset", allow);
    end
    reset = 1'b1;
    v = 1'b0;
    @(negedge clk);
    checks++;
    if (allow !== 1'b1 || empty !== 1'b1 || {wen, pc, wnum, wdata} !== '0) begin
      failures++;
      $display("FAIL rst_mid_clear: allowin=%b empty=%b wen=%h pc=%h wnum=%0d wdata=%h, required 1 1 0 0 0 0",
               allow, empty, wen, pc, wnum, wdata);
    end
    expq.delete();
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++;
      if (wen !== 4'h0 || empty !== 1'b1) begin
        failures++;
        $display("FAIL rst_mid_stale: cycle %0d wen=%h pc=%h empty=%b, required 0 - 1", c, wen, pc, empty);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_dual();
    test_backpressure();
    test_nonwrite();
    test_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
